// File: rtl/gardner_nco_interp.sv
// Gardner symbol-timing front end: a decrementing NCO picks interpolation instants
// from a 4-sample history, and a parabolic Farrow interpolator (alpha = 0.5) computes the interpolant.
module gardner_nco_interp #(
  parameter int          DW       = 16,
  parameter logic [15:0] ETA_INIT = 16'h4000,
  parameter int          LAT      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  input  logic        [15:0]   wk,
  output logic                 strobe,
  output logic signed [17:0]   data_out,
  output logic        [15:0]   mu_out
);

  localparam int CW  = DW + 3;   // Farrow coefficient width
  localparam int PW  = CW + 17;  // c2 * mu product
  localparam int TW  = CW + 2;   // (c2*mu >>> 16) + c1
  localparam int PW2 = TW + 17;  // t * mu product
  localparam int YW  = TW + 2;   // unsaturated interpolant

  if (LAT != 3) begin : g_lat_check
    $error("gardner_nco_interp: LAT is fixed at 3");
  end

  logic signed [DW-1:0] hist_q [4];
  logic signed [DW-1:0] hist_d [4];
  logic signed [CW-1:0] x_e    [4];

  // hist_d is the history as it will look once the current sample is accepted
  for (genvar gi = 0; gi < 4; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_d[gi] = din;
    end else begin : g_tail
      assign hist_d[gi] = hist_q[gi-1];
    end
    assign x_e[gi] = CW'(hist_d[gi]);

    always_ff @(posedge clk) begin
      if (reset) begin
        hist_q[gi] <= '0;
      end else if (din_valid) begin
        hist_q[gi] <= hist_d[gi];
      end
    end
  end

  logic        [15:0] wk_c;
  logic        [15:0] eta_q;
  logic        [15:0] eta_d;
  logic signed [16:0] diff;
  logic               under;

  always_comb begin
    if ($signed(wk) < 16'sh2000) begin
      wk_c = 16'h2000;
    end else if ($signed(wk) > 16'sh6000) begin
      wk_c = 16'h6000;
    end else begin
      wk_c = wk;
    end
  end

  assign diff  = $signed({1'b0, eta_q}) - $signed({1'b0, wk_c});
  assign under = diff[16];
  assign eta_d = under ? diff[15:0] + 16'h8000 : diff[15:0];

  logic signed [CW-1:0] c2_d, c1_d;
  assign c2_d = (x_e[0] - x_e[1] - x_e[2] + x_e[3]) >>> 1;
  assign c1_d = (x_e[1] + x_e[1] + x_e[1] - x_e[0] - x_e[2] - x_e[3]) >>> 1;

  logic signed [CW-1:0] c2_q, c1_q, c0_q, c0b_q;
  logic        [15:0]   mu1_q, mu2_q;
  logic signed [TW-1:0] t_q, t_d;
  logic signed [YW-1:0] y_full;
  logic signed [17:0]   y_sat;
  logic                 v1_q, v2_q;
  logic                 strobe_q;
  logic signed [17:0]   data_q;
  logic        [15:0]   mu_q;

  // mu is an unsigned fraction, so it enters both products with a zero sign bit
  assign t_d    = TW'((PW'(c2_q) * PW'($signed({1'b0, mu1_q}))) >>> 16) + TW'(c1_q);
  assign y_full = YW'((PW2'(t_q) * PW2'($signed({1'b0, mu2_q}))) >>> 16) + YW'(c0b_q);

  always_comb begin
    if (64'(y_full) > 64'sd131071) begin
      y_sat = 18'sh1FFFF;
    end else if (64'(y_full) < -64'sd131072) begin
      y_sat = 18'sh20000;
    end else begin
      y_sat = 18'(y_full);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eta_q    <= ETA_INIT;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      mu_q     <= '0;
    end else begin
      v1_q     <= din_valid & under;
      v2_q     <= v1_q;
      strobe_q <= v2_q;
      if (din_valid) begin
        eta_q <= eta_d;
      end
      if (v2_q) begin
        data_q <= y_sat;
        mu_q   <= mu2_q;
      end
    end
  end

  // Datapath stages carry no reset: they are only consumed under their valid bits
  always_ff @(posedge clk) begin
    if (din_valid && under) begin
      c2_q  <= c2_d;
      c1_q  <= c1_d;
      c0_q  <= x_e[2];
      mu1_q <= {eta_q[14:0], 1'b0};
    end
    if (v1_q) begin
      t_q   <= t_d;
      c0b_q <= c0_q;
      mu2_q <= mu1_q;
    end
  end

  assign strobe   = strobe_q;
  assign data_out = data_q;
  assign mu_out   = mu_q;

endmodule

// File: tb/tb_gardner_nco_interp.sv
// Randomized bench for gardner_nco_interp: an integer reference model predicts every
// strobe, interpolant and mu, and each cycle's outputs are compared against it.
module tb_gardner_nco_interp;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic        [15:0]   wk = 16'h4000;
  logic                 strobe;
  logic signed [17:0]   data_out;
  logic        [15:0]   mu_out;

  always #5 clk = ~clk;

  gardner_nco_interp #(.DW(DW), .ETA_INIT(16'h4000), .LAT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .din_valid(din_valid),
    .din      (din),
    .wk       (wk),
    .strobe   (strobe),
    .data_out (data_out),
    .mu_out   (mu_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint due;
    longint y;
    longint mu;
  } req_t;

  req_t   pend[$];
  longint hist[4];
  longint eta = 16384;
  longint held_y = 0;
  longint held_mu = 0;
  longint cyc = 0;
  bit     last_under = 0;

  function automatic longint fl(input longint a, input int k);
    longint dv;
    dv = longint'(1) << k;
    if (a >= 0) return a / dv;
    return -((-a + dv - 1) / dv);
  endfunction

  function automatic longint interp(input longint x0, input longint x1,
                                    input longint x2, input longint x3,
                                    input longint mu);
    longint c2, c1, c0, a, y;
    c2 = fl(x0 - x1 - x2 + x3, 1);
    c1 = fl(3 * x1 - x0 - x2 - x3, 1);
    c0 = x2;
    a  = fl(c2 * mu, 16) + c1;
    y  = fl(a * mu, 16) + c0;
    if (y > 131071)  y = 131071;
    if (y < -131072) y = -131072;
    return y;
  endfunction

  function automatic longint clamp_wk(input longint w);
    longint s;
    s = (w >= 32768) ? w - 65536 : w;
    if (s < 8192)  return 8192;
    if (s > 24576) return 24576;
    return s;
  endfunction

  // One clock cycle: check this cycle's outputs, then drive inputs for the next edge
  task automatic step(input bit r, input bit v, input longint x, input longint w);
    bit     exp_s;
    longint d, mu;
    req_t   e;
    @(negedge clk);
    exp_s = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e       = pend.pop_front();
      held_y  = e.y;
      held_mu = e.mu;
      exp_s   = 1'b1;
    end
    chk("strobe", strobe, exp_s);
    chk("data_out", data_out, held_y);
    chk("mu_out", mu_out, held_mu);
    if (strobe)
      $display("cyc %0d strobe data_out=%0d mu_out=0x%04h", cyc, data_out, mu_out);

    reset     = r;
    din_valid = v;
    din       = x[DW-1:0];
    wk        = w[15:0];

    last_under = 1'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) hist[i] = 0;
      eta     = 16384;
      pend.delete();
      held_y  = 0;
      held_mu = 0;
    end else if (v) begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = x;
      d = eta - clamp_wk(w);
      if (d >= 0) begin
        eta = d;
      end else begin
        mu  = 2 * eta;
        eta = d + 32768;
        pend.push_back('{due: cyc + 3,
                         y: interp(hist[0], hist[1], hist[2], hist[3], mu),
                         mu: mu});
        last_under = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 16'h4000);
  endtask

  function automatic longint rnd_s16();
    return longint'($signed(16'($urandom)));
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) hist[i] = 0;
    repeat (2) @(posedge clk);
    do_reset(3);

    // nominal ramp, wk = 0.5
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, i, 16'h4000);

    // DC input with a non-integer ratio
    do_reset(2);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1000, 16'h3000);

    // clamp behaviour, including values right at and past the limits
    do_reset(2);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, rnd_s16(), 16'hF000);
    do_reset(2);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, rnd_s16(), 16'h7FFF);
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      longint wl;
      case (i % 5)
        0: wl = 16'h1FFF;
        1: wl = 16'h2000;
        2: wl = 16'h6000;
        3: wl = 16'h6001;
        default: wl = 16'h8000;
      endcase
      step(1'b0, 1'b1, rnd_s16(), wl);
    end

    // gapped valid carrying the same ramp
    do_reset(2);
    for (int i = 0; i < 48; i++) step(1'b0, (i % 2) == 0, (i % 2 == 0) ? i / 2 : rnd_s16(), 16'h4000);

    // full-scale alternating input with large mu
    do_reset(2);
    for (int i = 0; i < 120; i++)
      step(1'b0, 1'b1, (i % 2 == 0) ? 32767 : -32768, $urandom_range(16'h5000, 16'h7FFF));

    // reset one cycle after an underflow, with din_valid held high through it
    for (int rep = 0; rep < 3; rep++) begin
      int n;
      do_reset(2);
      n = 0;
      last_under = 1'b0;
      while (!last_under && n < 16) begin
        step(1'b0, 1'b1, 100 + n, 16'h4000);
        n++;
      end
      step(1'b1, 1'b1, 555, 16'h4000);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 200 + i, 16'h4000);
    end

    // random soak
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      bit     r, v;
      longint wl;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      wl = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                       : longint'($urandom_range(16'h2000, 16'h6000));
      step(r, v, rnd_s16(), wl);
    end

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 16'h4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
